// File: rtl/ser_pkg.sv
// Shared serial-link definitions: FSM state encoding and bit-counter sizing.
// Used by the PISO transmitter and the receiver-side framing block.
package ser_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SHIFT  = 2'd1,
      S_PARITY = 2'd2
   } ser_state_e;

   // Width of a counter that must hold the values 0..width.
   function automatic int cnt_w(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/piso_shift_core.sv
// Loadable WIDTH-bit shift register for the serializer.
// dir=0 shifts toward the MSB (MSB leaves first), dir=1 shifts toward the LSB.
// tap is the bit that will sit at the line end once the next shift happens.
module piso_shift_core #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load,
   input  logic             shift,
   input  logic             dir,
   input  logic [WIDTH-1:0] d,
   output logic             tap
);

   logic [WIDTH-1:0] sreg;

   // Load has priority over shift; zeros fill the vacated end.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sreg <= '0;
      end else if (load) begin
         sreg <= d;
      end else if (shift) begin
         if (dir) begin
            sreg <= {1'b0, sreg[WIDTH-1:1]};
         end else begin
            sreg <= {sreg[WIDTH-2:0], 1'b0};
         end
      end
   end

   assign tap = dir ? sreg[1] : sreg[WIDTH-2];

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter with valid/ready word intake and a bit-rate tick.
// Optional even-parity bit appended after the data when SER_PARITY_EN is defined.
// Back-to-back frames are accepted on the tick that retires the final frame bit.
module piso_serializer
   import ser_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter bit LSB_FIRST = 1'b0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   input  logic             bit_en,
   output logic             sout,
   output logic             sout_valid,
   output logic             frame_start,
   output logic             busy
);

   localparam int            CW       = cnt_w(WIDTH);
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   ser_state_e    state, state_nxt;
   logic [CW-1:0] count, count_nxt;
   logic          sout_nxt, sout_valid_nxt, frame_start_nxt;
   logic          ready, frame_end, load, shift;
   logic          shift_tap, first_bit;

   assign first_bit = LSB_FIRST ? din[0] : din[WIDTH-1];

   piso_shift_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (load),
      .shift   (shift),
      .dir     (LSB_FIRST),
      .d       (din),
      .tap     (shift_tap)
   );

`ifdef SER_PARITY_EN
   logic parity;

   // Even parity of the accepted word, captured alongside the load.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         parity <= 1'b0;
      end else if (load) begin
         parity <= ^din;
      end
   end
`endif

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state, handshake and next line values; intake overrides the end-of-frame path.
   always_comb begin
      state_nxt       = state;
      count_nxt       = count;
      sout_nxt        = sout;
      sout_valid_nxt  = sout_valid;
      frame_start_nxt = frame_start;
      ready           = 1'b0;
      frame_end       = 1'b0;
      load            = 1'b0;
      shift           = 1'b0;

      case (state)
         S_IDLE: begin
            ready = 1'b1;
         end
         S_SHIFT: begin
            if (bit_en) begin
               frame_start_nxt = 1'b0;
               shift           = 1'b1;
               if (count != LAST_CNT) begin
                  count_nxt = count + CW'(1);
                  sout_nxt  = shift_tap;
               end else begin
`ifdef SER_PARITY_EN
                  state_nxt = S_PARITY;
                  sout_nxt  = parity;
`else
                  ready     = 1'b1;
                  frame_end = 1'b1;
`endif
               end
            end
         end
`ifdef SER_PARITY_EN
         S_PARITY: begin
            if (bit_en) begin
               ready     = 1'b1;
               frame_end = 1'b1;
            end
         end
`endif
         default: begin
            state_nxt = S_IDLE;
         end
      endcase

      if (ready && din_valid) begin
         load            = 1'b1;
         state_nxt       = S_SHIFT;
         count_nxt       = '0;
         sout_nxt        = first_bit;
         sout_valid_nxt  = 1'b1;
         frame_start_nxt = 1'b1;
      end else if (frame_end) begin
         state_nxt       = S_IDLE;
         count_nxt       = '0;
         sout_nxt        = 1'b0;
         sout_valid_nxt  = 1'b0;
         frame_start_nxt = 1'b0;
      end
   end

   // Bit counter and registered line outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count       <= '0;
         sout        <= 1'b0;
         sout_valid  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         count       <= count_nxt;
         sout        <= sout_nxt;
         sout_valid  <= sout_valid_nxt;
         frame_start <= frame_start_nxt;
      end
   end

   // Ready is held low while reset is asserted so every output reads 0 in reset.
   assign din_ready = ready & reset_n;
   assign busy      = (state != S_IDLE);

endmodule
